l2_line_hub: RTL and testbench
==============================

# l2_line_hub

Parametrised shared L2 line hub between NUM_CORES core ports and the upstream ring. Direct-mapped, tagged, line-granular store with round-robin core arbitration. Hits are served from the local array. Misses refill a whole line over the ring before the line is returned. Replaces the fixed four-core L2/ring front end in the supercore.

## Interface
- NUM_CORES, 4, requesting core ports (≥2)
- DATA_W, 64, word width
- ADDR_W, 64, byte address width
- LINE_WORDS, 8, words per line (power of 2)
- NUM_LINES, 64, direct-mapped sets (power of 2)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- core_req  in  NUM_CORES  per-core line request; held until matching core_ready
- core_addr  in  NUM_CORES*ADDR_W  packed byte addresses; core i at [i*ADDR_W +: ADDR_W]
- core_ready  out  NUM_CORES  one-hot, one-cycle response pulse
- core_rdata  out  LINE_WORDS*DATA_W  returned line; word k at [k*DATA_W +: DATA_W]
- inv_all  in  1  pulse; invalidate all lines
- ring_req  out  1  line fetch request
- ring_addr  out  ADDR_W  line-aligned fetch address
- ring_ready  in  1  ring line valid this cycle
- ring_rdata  in  LINE_WORDS*DATA_W  packed refill line

## Operation
- Address split: OFF = log2(LINE_WORDS*DATA_W/8) low bits ignored; next log2(NUM_LINES) bits = index; remaining upper bits = tag.
- Storage: data array NUM_LINES x LINE_WORDS words, tag array, valid bit per set.
- FSM states: IDLE, LOOKUP, REFILL, XFER, RESP.
- IDLE:
  - Apply pending invalidate first.
  - Otherwise grant the first requesting core at or after rr_ptr, in increasing index order with wrap.
  - Register grant index and address, then go to LOOKUP.
- LOOKUP:
  - Hit = valid[index] && tag matches. Hit goes to XFER.
  - Miss goes to REFILL.
- REFILL:
  - Hold ring_req=1 and ring_addr = granted address with low OFF bits cleared.
  - On ring_ready: write all LINE_WORDS words, tag and valid[index]=1 in one cycle.
  - Drop ring_req the same edge, then go to XFER. This evicts any previous line in the set.
- XFER:
  - Copy one word per cycle, k=0..LINE_WORDS-1, from the array into the core_rdata register.
  - Go to RESP after word LINE_WORDS-1.
- RESP:
  - core_ready[grant]=1 for exactly one cycle.
  - rr_ptr = (grant+1) mod NUM_CORES, then return to IDLE.
- core_rdata holds its last value until the next XFER overwrites it.
- A granted transaction always completes, even if core_req drops mid-service.
- inv_all while not in IDLE: latched as pending and applied on the next IDLE cycle, before arbitration. That cycle grants nothing.
- inv_all in IDLE: clears valid bits that cycle. No grant that cycle.
- inv_all does not abort an in-flight refill. The refilled line is invalidated by the pending clear afterwards.
- ring_ready is ignored unless ring_req=1.
- Reset mid-operation: abort immediately. ring_req drops at the reset edge and any partial refill is discarded.

## Timing
- Reset values:
  - ring_req=0, ring_addr=0
  - core_ready=0, core_rdata=0
  - all valid bits 0, rr_ptr=0, pending invalidate 0
  - state IDLE
- Request sampled at edge T (IDLE), so LOOKUP occupies T+1.
- Hit: XFER occupies T+2..T+1+LINE_WORDS. core_ready pulses at T+2+LINE_WORDS (10 cycles with defaults). Back in IDLE at T+3+LINE_WORDS.
- Miss: ring_req rises at T+2. With ring_ready at cycle R, XFER runs R+1..R+LINE_WORDS and core_ready pulses at R+LINE_WORDS+1.
- Minimum spacing between responses: LINE_WORDS+3 cycles.
- Only one transaction is in flight. No stalls other than ring latency.

## Test plan
- Reset: assert rst 3 cycles mid-refill. Required: ring_req=0, core_ready=0, core_rdata=0 next cycle, and the next access to the same address misses.
- Cold miss then hit, core 0, addr 0x1040:
  - ring_addr=0x1040 at T+2.
  - ring_ready at T+5 with words 0xA0..0xA7 gives core_ready[0] at T+14 with those words.
  - Repeat to the same address: hit, ring_req stays 0, ready at T+10.
- Round robin: all four cores request distinct hit addresses. Grants must be 0,1,2,3. Then core 2 alone, and core 0 plus core 3 together, must grant 3 before 0.
- Conflict eviction: 0x0000 then 0x1000 (same index, default params) both miss. Re-reading 0x0000 misses again, with ring_addr=0x0000.
- inv_all pulsed during XFER of a hit: the response still completes with correct data, and a subsequent request to the same line misses.
- ring_ready held low 20 cycles: ring_ready asserted while ring_req=0 beforehand is ignored. ring_req and ring_addr stay stable throughout, and the response arrives LINE_WORDS+1 cycles after ring_ready.

Source files
------------

// File: rtl/l2_line_hub.sv
// Shared direct-mapped L2 line hub: round-robin core arbitration, full-line ring refill on miss,
// word-serial return into a registered response line. One transaction in flight.

module l2_line_hub_lane #(
  parameter int ADDR_W = 64,
  parameter int OFF    = 6
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic [ADDR_W-OFF-1:0] line_o
);
  // Byte offset within the line never affects lookup.
  logic unused_off;
  assign unused_off = ^addr_i[OFF-1:0];
  assign line_o     = addr_i[ADDR_W-1:OFF];
endmodule

module l2_line_hub #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int LINE_WORDS = 8,
  parameter int NUM_LINES  = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CORES-1:0]             core_req,
  input  logic [NUM_CORES*ADDR_W-1:0]      core_addr,
  output logic [NUM_CORES-1:0]             core_ready,
  output logic [LINE_WORDS*DATA_W-1:0]     core_rdata,
  input  logic                             inv_all,
  output logic                             ring_req,
  output logic [ADDR_W-1:0]                ring_addr,
  input  logic                             ring_ready,
  input  logic [LINE_WORDS*DATA_W-1:0]     ring_rdata
);
  localparam int OFF = $clog2(LINE_WORDS*DATA_W/8);
  localparam int IW  = $clog2(NUM_LINES);
  localparam int LNW = ADDR_W - OFF;
  localparam int TW  = LNW - IW;
  localparam int CW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int KW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef logic [LINE_WORDS-1:0][DATA_W-1:0] line_t;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, XFER, RESP} state_t;

  logic [NUM_CORES-1:0][ADDR_W-1:0] core_addr_a;
  logic [NUM_CORES-1:0][LNW-1:0]    core_line;
  assign core_addr_a = core_addr;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    l2_line_hub_lane #(.ADDR_W(ADDR_W), .OFF(OFF)) u_lane (
      .addr_i (core_addr_a[i]),
      .line_o (core_line[i])
    );
  end

  state_t                 state_q;
  logic [CW-1:0]          grant_q, rr_q;
  logic [LNW-1:0]         line_q;
  logic [KW-1:0]          k_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic                   inv_pend_q;
  logic                   ring_req_q;
  logic [ADDR_W-1:0]      ring_addr_q;
  logic [NUM_CORES-1:0]   core_ready_q;
  line_t                  rdata_q;

  line_t                  data_mem [NUM_LINES];
  logic [TW-1:0]          tag_mem  [NUM_LINES];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          hit;
  assign idx = line_q[IW-1:0];
  assign tag = line_q[LNW-1:IW];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  logic          gnt_vld;
  logic [CW-1:0] gnt_idx, cand;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      cand = CW'((int'(rr_q) + j) % NUM_CORES);
      if (!gnt_vld && core_req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // A refill landing on the reset edge is discarded.
  logic refill_we;
  assign refill_we = (state_q == REFILL) && ring_ready && !rst;

  always_ff @(posedge clk) begin
    if (refill_we) begin
      data_mem[idx] <= ring_rdata;
      tag_mem[idx]  <= tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_q         <= '0;
      line_q       <= '0;
      k_q          <= '0;
      valid_q      <= '0;
      inv_pend_q   <= 1'b0;
      ring_req_q   <= 1'b0;
      ring_addr_q  <= '0;
      core_ready_q <= '0;
      rdata_q      <= '0;
    end else begin
      if (inv_all && state_q != IDLE) inv_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          // Invalidate takes the whole IDLE cycle; arbitration waits one more.
          if (inv_all || inv_pend_q) begin
            valid_q    <= '0;
            inv_pend_q <= 1'b0;
          end else if (gnt_vld) begin
            grant_q <= gnt_idx;
            line_q  <= core_line[gnt_idx];
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          k_q <= '0;
          if (hit) begin
            state_q <= XFER;
          end else begin
            ring_req_q  <= 1'b1;
            ring_addr_q <= {line_q, {OFF{1'b0}}};
            state_q     <= REFILL;
          end
        end
        REFILL: begin
          if (ring_ready) begin
            valid_q[idx] <= 1'b1;
            ring_req_q   <= 1'b0;
            state_q      <= XFER;
          end
        end
        XFER: begin
          rdata_q[k_q] <= data_mem[idx][k_q];
          k_q          <= k_q + 1'b1;
          if (k_q == KW'(LINE_WORDS-1)) begin
            core_ready_q[grant_q] <= 1'b1;
            state_q               <= RESP;
          end
        end
        RESP: begin
          core_ready_q <= '0;
          rr_q         <= (grant_q == CW'(NUM_CORES-1)) ? '0 : grant_q + 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ring_req   = ring_req_q;
  assign ring_addr  = ring_addr_q;
  assign core_ready = core_ready_q;
  assign core_rdata = rdata_q;
endmodule

// File: tb/tb_l2_line_hub.sv
// Bench for l2_line_hub: transaction-timeline reference model compared every cycle,
// plus directed latency/arbitration/eviction/invalidate/reset scenarios and a random phase.

module tb_l2_line_hub;
  localparam int NC     = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int LW     = 8;
  localparam int NL     = 64;
  localparam int OFF    = 6;
  localparam int LBITS  = LW*DATA_W;

  typedef logic [LW-1:0][DATA_W-1:0] line_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NC-1:0]        core_req;
  logic [NC*ADDR_W-1:0] core_addr;
  logic [NC-1:0]        core_ready;
  logic [LBITS-1:0]     core_rdata;
  logic                 inv_all;
  logic                 ring_req;
  logic [ADDR_W-1:0]    ring_addr;
  logic                 ring_ready;
  logic [LBITS-1:0]     ring_rdata;

  always #5 clk = ~clk;

  l2_line_hub #(.NUM_CORES(NC), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                .LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_addr  (core_addr),
    .core_ready (core_ready),
    .core_rdata (core_rdata),
    .inv_all    (inv_all),
    .ring_req   (ring_req),
    .ring_addr  (ring_addr),
    .ring_ready (ring_ready),
    .ring_rdata (ring_rdata)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [LBITS-1:0] act, input logic [LBITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    chk(nm, LBITS'(act), LBITS'(exp));
  endtask

  // Reference model: cache contents as line addresses per set, driven as a transaction timeline.
  logic [ADDR_W-1:0] m_line [NL];
  bit                m_val  [NL];
  line_t             m_data [NL];
  int                m_rr;
  bit                m_pend;
  logic              exp_rreq;
  logic [ADDR_W-1:0] exp_raddr;
  logic [NC-1:0]     exp_ready;
  line_t             exp_rdata;

  task automatic m_reset();
    for (int s = 0; s < NL; s++) m_val[s] = 0;
    m_rr = 0; m_pend = 0;
    exp_rreq = 0; exp_raddr = '0; exp_ready = '0; exp_rdata = '0;
  endtask

  task automatic step(output bit ab);
    @(posedge clk);
    ab = rst;
    if (!rst && inv_all) m_pend = 1;
  endtask

  task automatic m_serve(input int g, input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] ln;
    int set;
    bit hit, ab;
    ln  = a >> OFF;
    set = int'(ln % NL);
    hit = m_val[set] && (m_line[set] == ln);
    step(ab);
    if (ab) begin m_reset(); return; end
    if (!hit) begin
      exp_rreq  = 1;
      exp_raddr = ln << OFF;
      forever begin
        step(ab);
        if (ab || ring_ready) break;
      end
      if (ab) begin m_reset(); return; end
      m_data[set] = ring_rdata;
      m_line[set] = ln;
      m_val[set]  = 1;
      exp_rreq    = 0;
    end
    for (int k = 0; k < LW; k++) begin
      step(ab);
      if (ab) begin m_reset(); return; end
      exp_rdata[k] = m_data[set][k];
    end
    exp_ready[g] = 1;
    step(ab);
    if (ab) begin m_reset(); return; end
    exp_ready = '0;
    m_rr = (g + 1) % NC;
  endtask

  initial begin : model
    int g;
    m_reset();
    forever begin
      @(posedge clk);
      if (rst) m_reset();
      else if (inv_all || m_pend) begin
        for (int s = 0; s < NL; s++) m_val[s] = 0;
        m_pend = 0;
      end else begin
        g = -1;
        for (int j = 0; j < NC; j++)
          if (g < 0 && core_req[(m_rr + j) % NC]) g = (m_rr + j) % NC;
        if (g >= 0) m_serve(g, core_addr[g*ADDR_W +: ADDR_W]);
      end
    end
  end

  initial begin : cmp
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("ring_req", LBITS'(ring_req), LBITS'(exp_rreq));
        if (exp_rreq) chk("ring_addr", LBITS'(ring_addr), LBITS'(exp_raddr));
        chk("core_ready", LBITS'(core_ready), LBITS'(exp_ready));
        chk("core_rdata", core_rdata, exp_rdata);
      end
    end
  end

  // Stimulus helpers
  bit                spur = 0;
  bit                fix_base = 0;
  int                g_lat [NC];
  int                g_order [$];
  int                g_first_rr, g_rready_cnt;
  logic [ADDR_W-1:0] g_raddr;
  line_t             g_fill;

  function automatic line_t rand_line();
    line_t l;
    for (int k = 0; k < LW; k++) l[k] = {$urandom, $urandom};
    return l;
  endfunction

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
    core_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic serve(input logic [NC-1:0] mask, input int rlat, input int inv_at);
    int cnt, rc;
    line_t l;
    g_order.delete();
    g_first_rr = -1; g_rready_cnt = -1; g_raddr = '0;
    for (int i = 0; i < NC; i++) g_lat[i] = -1;
    @(negedge clk);
    core_req = mask;
    cnt = 0; rc = 0;
    while (core_req != '0 && cnt < 600) begin
      @(negedge clk);
      cnt++;
      inv_all = (cnt == inv_at);
      if (ring_req) begin
        if (g_first_rr < 0) begin g_first_rr = cnt; g_raddr = ring_addr; end
        rc++;
        if (rc == rlat) begin
          if (fix_base) for (int k = 0; k < LW; k++) l[k] = 64'hA0 + 64'(k);
          else l = rand_line();
          g_fill = l; ring_rdata = l; ring_ready = 1; g_rready_cnt = cnt;
        end else ring_ready = 0;
      end else begin
        rc = 0;
        ring_ready = spur && ($urandom_range(0, 2) == 0);
        ring_rdata = rand_line();
      end
      for (int i = 0; i < NC; i++)
        if (core_ready[i] && core_req[i]) begin
          core_req[i] = 0; g_lat[i] = cnt; g_order.push_back(i);
        end
    end
    ring_ready = 0;
    inv_all = 0;
    if (core_req != '0) begin
      chk("serve_timeout", LBITS'(core_req), '0);
      core_req = '0;
    end
  endtask

  initial begin : main
    line_t saved;
    int    wait_cnt;
    rst = 1; core_req = '0; core_addr = '0; inv_all = 0; ring_ready = 0; ring_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_ring_req", LBITS'(ring_req), '0);
    chk("reset_ring_addr", LBITS'(ring_addr), '0);
    chk("reset_core_ready", LBITS'(core_ready), '0);
    chk("reset_core_rdata", core_rdata, '0);
    chk_on = 1;

    // Cold miss then hit, core 0 at 0x1040
    fix_base = 1;
    set_addr(0, 64'h1040);
    serve(4'b0001, 4, 0);
    chki("cold_ring_rise", g_first_rr, 2);
    chk("cold_ring_addr", LBITS'(g_raddr), LBITS'(64'h1040));
    chki("cold_ready_lat", g_lat[0], 14);
    chk("cold_word0", LBITS'(core_rdata[63:0]), LBITS'(64'hA0));
    chk("cold_word7", LBITS'(core_rdata[LBITS-1 -: 64]), LBITS'(64'hA7));
    serve(4'b0001, 4, 0);
    chki("hit_no_ring", g_first_rr, -1);
    chki("hit_ready_lat", g_lat[0], 10);
    chk("hit_word3", LBITS'(core_rdata[3*64 +: 64]), LBITS'(64'hA3));
    fix_base = 0;

    // Round robin over four primed hit lines
    for (int i = 0; i < NC; i++) begin
      set_addr(i, 64'h2000 + 64'(i)*64'h40);
      serve(4'(1 << i), 3, 0);
    end
    serve(4'b1111, 3, 0);
    chki("rr_count", g_order.size(), 4);
    for (int i = 0; i < 4 && i < g_order.size(); i++) chki("rr_order", g_order[i], i);
    chki("rr_all_hit", g_first_rr, -1);
    chki("rr_spacing", g_lat[1] - g_lat[0], 11);
    serve(4'b0100, 3, 0);
    chki("rr_single_2", g_order.size() > 0 ? g_order[0] : -1, 2);
    serve(4'b1001, 3, 0);
    chki("rr_wrap_first", g_order.size() > 0 ? g_order[0] : -1, 3);
    chki("rr_wrap_second", g_order.size() > 1 ? g_order[1] : -1, 0);

    // Conflict eviction in set 0
    set_addr(0, 64'h0000); serve(4'b0001, 2, 0);
    chki("evict_miss_a", g_first_rr, 2);
    set_addr(0, 64'h1000); serve(4'b0001, 2, 0);
    chki("evict_miss_b", g_first_rr, 2);
    set_addr(0, 64'h0000); serve(4'b0001, 2, 0);
    chki("evict_remiss", g_first_rr, 2);
    chk("evict_ring_addr", LBITS'(g_raddr), '0);
    saved = g_fill;

    // Invalidate during XFER of a hit; the clear costs one IDLE cycle before the next grant
    serve(4'b0001, 2, 5);
    chki("inv_hit", g_first_rr, -1);
    chki("inv_hit_lat", g_lat[0], 10);
    chk("inv_hit_data", core_rdata, saved);
    serve(4'b0001, 2, 0);
    chki("inv_then_miss", g_first_rr, 3);

    // Long ring stall with stray ring_ready while idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ring_ready = 1; ring_rdata = rand_line();
    end
    @(negedge clk);
    ring_ready = 0;
    spur = 1;
    set_addr(3, 64'h4100);
    serve(4'b1000, 21, 0);
    chki("stall_ring_rise", g_first_rr, 2);
    chki("stall_ready_cyc", g_rready_cnt, 22);
    chki("stall_resp_lat", g_lat[3], 31);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NC; i++)
        set_addr(i, (64'($urandom_range(0, 3)) << 12) | (64'($urandom_range(0, 7)) << 6)
                    | 64'($urandom_range(0, 63)));
      serve(4'($urandom_range(1, 15)), $urandom_range(1, 5),
            ($urandom_range(0, 4) == 0) ? $urandom_range(1, 30) : 0);
    end
    spur = 0;

    // Reset for 3 cycles in the middle of a refill
    set_addr(1, 64'h3080);
    set_addr(0, 64'h2000);
    @(negedge clk);
    core_req = 4'b0010;
    wait_cnt = 0;
    while (!ring_req && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    chki("rst_refill_started", int'(ring_req), 1);
    repeat (2) @(negedge clk);
    rst = 1; core_req = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ring_req", LBITS'(ring_req), '0);
    chk("rst_core_ready", LBITS'(core_ready), '0);
    chk("rst_core_rdata", core_rdata, '0);
    serve(4'b0010, 2, 0);
    chki("rst_same_addr_miss", g_first_rr, 2);
    serve(4'b0001, 2, 0);
    chki("rst_old_line_miss", g_first_rr, 2);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
